icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache with one 32-bit word per line.
- Sits between the IF stage, which consumes its output, and memctrl's instruction port, which it drives.
- Hits return an instruction in the request cycle without touching memctrl.
- Misses issue one word fetch to memctrl, fill the line, then return the word.
- Holds 32-bit hit and miss performance counters for debug readout.

---
 rtl/icache_direct.sv | 223 ++++++++++++++++++++++
 tb/tb_icache_direct.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache, one 32-bit word per line.
//   Sits between the IF stage (consumer) and the memory controller's
//   instruction port. Hits answer combinationally in the request cycle;
//   misses fetch one word from memctrl, fill the line and answer one cycle
//   after the fetch completes. Hit and miss counters are kept for debug.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   rdy_in           global ready; low freezes every register and array
//   if_req_in        IF requests the instruction at if_addr_in
//   if_addr_in       fetch address, bits [1:0] ignored
//   flush_in         branch taken; abandons any outstanding request
//   instr_valid_out  instr_out holds the word for the current if_addr_in
//   instr_out        instruction word (0 when not valid)
//   mc_req_out       word fetch request to memctrl (held until mc_done_in)
//   mc_addr_out      word-aligned fetch address
//   mc_done_in       memctrl fetch complete, one-cycle pulse
//   mc_data_in       fetched word, valid while mc_done_in is high
//   hit_cnt_out      32-bit wrapping hit counter
//   miss_cnt_out     32-bit wrapping miss counter
//
// Handshake: the request to memctrl is a level. mc_req_out rises on the edge
// that enters MISS and stays high, with mc_addr_out stable, until the edge
// on which mc_done_in is sampled high. mc_done_in outside MISS is ignored.
// ---------------------------------------------------------------------------
module icache_direct #(
   parameter int IDX_W  = 6,
   parameter int ADDR_W = 18
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        if_req_in,
   input  logic [31:0] if_addr_in,
   input  logic        flush_in,
   output logic        instr_valid_out,
   output logic [31:0] instr_out,
   output logic        mc_req_out,
   output logic [31:0] mc_addr_out,
   input  logic        mc_done_in,
   input  logic [31:0] mc_data_in,
   output logic [31:0] hit_cnt_out,
   output logic [31:0] miss_cnt_out
);

   localparam int LINES = 1 << IDX_W;
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MISS = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Line storage. Only the valid bits are reset; tag and data contents are
   // meaningless until their valid bit is set by a fill.
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   // Outstanding miss bookkeeping.
   logic [29:0] miss_addr_q;   // word address of the miss being serviced
   logic        drop_q;        // a flush arrived while the miss was in flight
   logic [31:0] resp_q;        // fetched word, replayed in RESP

   logic        mc_req_q;
   logic [31:0] mc_addr_q;
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Lookup on the live IF address.
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic             hit;

   assign req_idx = if_addr_in[IDX_W+1:2];
   assign req_tag = if_addr_in[ADDR_W-1:IDX_W+2];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   // Fill target comes from the latched miss address, not the live one,
   // because IF may move its address while the miss is outstanding.
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;

   assign fill_idx = miss_addr_q[IDX_W-1:0];
   assign fill_tag = miss_addr_q[ADDR_W-3:IDX_W];

   // Address bits [1:0] select a byte within the word and play no part here.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, if_addr_in[1:0]};

   // Per-cycle events produced by the FSM.
   logic        hit_evt;
   logic        miss_evt;
   logic        fill_evt;
   logic        resp_match;
   logic        out_valid;
   logic [31:0] out_word;

   assign resp_match = (if_addr_in[31:2] == miss_addr_q) && !flush_in;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else if (rdy_in) begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and combinational outputs
   // With rdy_in low nothing is reported or counted, so a frozen cycle never
   // presents a word that the counters did not see.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      hit_evt   = 1'b0;
      miss_evt  = 1'b0;
      fill_evt  = 1'b0;
      out_valid = 1'b0;
      out_word  = 32'd0;

      if (rdy_in) begin
         unique case (state_q)
            IDLE: begin
               if (if_req_in && !flush_in) begin
                  if (hit) begin
                     out_valid = 1'b1;
                     out_word  = data_mem[req_idx];
                     hit_evt   = 1'b1;
                  end else begin
                     miss_evt = 1'b1;
                     state_d  = MISS;
                  end
               end
            end
            MISS: begin
               if (mc_done_in) begin
                  fill_evt = 1'b1;
                  // A flush now or earlier in the miss still fills the line
                  // but suppresses the reply.
                  state_d  = (drop_q || flush_in) ? IDLE : RESP;
               end
            end
            RESP: begin
               if (resp_match) begin
                  out_valid = 1'b1;
                  out_word  = resp_q;
               end
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign instr_valid_out = out_valid;
   assign instr_out       = out_word;

   // ------------------------------------------------------------------------
   // Control registers: valid bits, miss bookkeeping, memctrl request,
   // counters.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q     <= '0;
         miss_addr_q <= '0;
         drop_q      <= 1'b0;
         resp_q      <= '0;
         mc_req_q    <= 1'b0;
         mc_addr_q   <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else if (rdy_in) begin
         if (hit_evt) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end

         if (miss_evt) begin
            miss_cnt_q  <= miss_cnt_q + 32'd1;
            miss_addr_q <= if_addr_in[31:2];
            mc_addr_q   <= {if_addr_in[31:2], 2'b00};
            mc_req_q    <= 1'b1;
            drop_q      <= 1'b0;
         end else if (state_q == MISS && flush_in) begin
            drop_q <= 1'b1;
         end

         if (fill_evt) begin
            valid_q[fill_idx] <= 1'b1;
            resp_q            <= mc_data_in;
            mc_req_q          <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Tag and data arrays (no reset). A fill always overwrites the line, so
   // the last fill to an index wins.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rdy_in && fill_evt) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mc_data_in;
      end
   end

   assign mc_req_out   = mc_req_q;
   assign mc_addr_out  = mc_addr_q;
   assign hit_cnt_out  = hit_cnt_q;
   assign miss_cnt_out = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//   Directed bench for icache_direct. A behavioural model tracks which word
//   address each line holds, the outstanding fetch and the counters; a
//   negedge compare process checks every DUT output against it, and the
//   stimulus adds hand-computed literal checks at key points.
// ---------------------------------------------------------------------------
module tb_icache_direct;

   localparam int IDX_W  = 6;
   localparam int ADDR_W = 18;
   localparam int LINES  = 1 << IDX_W;

   // ------------------------------------------------------------------------
   // Clock / reset and DUT
   // ------------------------------------------------------------------------
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        if_req_in;
   logic [31:0] if_addr_in;
   logic        flush_in;
   logic        instr_valid_out;
   logic [31:0] instr_out;
   logic        mc_req_out;
   logic [31:0] mc_addr_out;
   logic        mc_done_in;
   logic [31:0] mc_data_in;
   logic [31:0] hit_cnt_out;
   logic [31:0] miss_cnt_out;

   always #5 clk_in = ~clk_in;

   icache_direct #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .if_req_in       (if_req_in),
      .if_addr_in      (if_addr_in),
      .flush_in        (flush_in),
      .instr_valid_out (instr_valid_out),
      .instr_out       (instr_out),
      .mc_req_out      (mc_req_out),
      .mc_addr_out     (mc_addr_out),
      .mc_done_in      (mc_done_in),
      .mc_data_in      (mc_data_in),
      .hit_cnt_out     (hit_cnt_out),
      .miss_cnt_out    (miss_cnt_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: a line "holds" a word address (modulo 2**ADDR_W);
   // a request hits when its word address is the one held by its line.
   // ------------------------------------------------------------------------
   bit                m_valid [LINES];
   logic [ADDR_W-3:0] m_word  [LINES];
   logic [31:0]       m_data  [LINES];
   bit                m_pend;
   bit                m_drop;
   bit                m_resp;
   logic [29:0]       m_pend_addr;
   logic [31:0]       m_resp_data;
   logic [31:0]       m_mc_addr;
   logic [31:0]       m_hit;
   logic [31:0]       m_miss;
   bit                cmp_en = 1'b0;

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % LINES);
   endfunction

   function automatic bit m_holds(input logic [31:0] a);
      logic [ADDR_W-3:0] w;
      w = a[ADDR_W-1:2];
      return m_valid[line_of(a)] && (m_word[line_of(a)] == w);
   endfunction

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
         m_pend      = 1'b0;
         m_drop      = 1'b0;
         m_resp      = 1'b0;
         m_pend_addr = '0;
         m_resp_data = '0;
         m_mc_addr   = '0;
         m_hit       = '0;
         m_miss      = '0;
      end else if (rdy_in) begin
         if (m_resp) begin
            m_resp = 1'b0;
         end else if (m_pend) begin
            if (flush_in) m_drop = 1'b1;
            if (mc_done_in) begin
               int l;
               l = line_of({m_pend_addr, 2'b00});
               m_valid[l]  = 1'b1;
               m_word[l]   = m_pend_addr[ADDR_W-3:0];
               m_data[l]   = mc_data_in;
               m_resp_data = mc_data_in;
               m_pend      = 1'b0;
               m_resp      = !m_drop;
            end
         end else if (if_req_in && !flush_in) begin
            if (m_holds(if_addr_in)) begin
               m_hit = m_hit + 32'd1;
            end else begin
               m_miss      = m_miss + 32'd1;
               m_pend      = 1'b1;
               m_drop      = 1'b0;
               m_pend_addr = if_addr_in[31:2];
               m_mc_addr   = {if_addr_in[31:2], 2'b00};
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk_in) begin
      if (cmp_en) begin
         logic        exp_v;
         logic [31:0] exp_w;
         exp_v = 1'b0;
         exp_w = 32'd0;
         if (rst_in && rdy_in) begin
            if (m_resp) begin
               if (if_addr_in[31:2] == m_pend_addr && !flush_in) begin
                  exp_v = 1'b1;
                  exp_w = m_resp_data;
               end
            end else if (!m_pend && if_req_in && !flush_in && m_holds(if_addr_in)) begin
               exp_v = 1'b1;
               exp_w = m_data[line_of(if_addr_in)];
            end
         end
         check("cmp_instr_valid", {31'd0, instr_valid_out}, {31'd0, exp_v});
         if (exp_v) check("cmp_instr_out", instr_out, exp_w);
         check("cmp_mc_req", {31'd0, mc_req_out}, {31'd0, m_pend});
         check("cmp_mc_addr", mc_addr_out, m_mc_addr);
         check("cmp_hit_cnt", hit_cnt_out, m_hit);
         check("cmp_miss_cnt", miss_cnt_out, m_miss);
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic set_req(input logic r, input logic [31:0] a);
      if_req_in  = r;
      if_addr_in = a;
   endtask

   // Called right after the edge that entered MISS; returns in the cycle
   // after the edge that sampled mc_done_in.
   task automatic fill(input logic [31:0] d, input int lat);
      step(lat);
      mc_done_in = 1'b1;
      mc_data_in = d;
      step();
      mc_done_in = 1'b0;
      mc_data_in = 32'd0;
   endtask

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst_in     = 1'b0;
      rdy_in     = 1'b1;
      if_req_in  = 1'b0;
      if_addr_in = 32'd0;
      flush_in   = 1'b0;
      mc_done_in = 1'b0;
      mc_data_in = 32'd0;

      // Reset state
      step(3);
      cmp_en = 1'b1;
      @(negedge clk_in);
      check("rst_instr_valid", {31'd0, instr_valid_out}, 32'd0);
      check("rst_instr_out", instr_out, 32'd0);
      check("rst_mc_req", {31'd0, mc_req_out}, 32'd0);
      check("rst_mc_addr", mc_addr_out, 32'd0);
      check("rst_hit_cnt", hit_cnt_out, 32'd0);
      check("rst_miss_cnt", miss_cnt_out, 32'd0);
      step();
      rst_in = 1'b1;
      step();

      // Cold miss at 0x100, fill 0x13, reply in RESP, then hit
      set_req(1'b1, 32'h0000_0100);
      @(negedge clk_in);
      check("t1_miss_no_valid", {31'd0, instr_valid_out}, 32'd0);
      step();
      @(negedge clk_in);
      check("t1_mc_req", {31'd0, mc_req_out}, 32'd1);
      check("t1_mc_addr", mc_addr_out, 32'h0000_0100);
      check("t1_miss_cnt", miss_cnt_out, 32'd1);
      fill(32'h0000_0013, 2);
      @(negedge clk_in);
      check("t1_resp_valid", {31'd0, instr_valid_out}, 32'd1);
      check("t1_resp_word", instr_out, 32'h0000_0013);
      step();
      @(negedge clk_in);
      check("t2_hit_valid", {31'd0, instr_valid_out}, 32'd1);
      check("t2_hit_word", instr_out, 32'h0000_0013);
      check("t2_hit_no_req", {31'd0, mc_req_out}, 32'd0);
      step();
      set_req(1'b0, 32'd0);
      @(negedge clk_in);
      check("t2_hit_cnt", hit_cnt_out, 32'd1);
      step();

      // Conflict: 0x200 evicts 0x100 (same line, different tag)
      set_req(1'b1, 32'h0000_0200);
      step();
      @(negedge clk_in);
      check("t3_mc_addr", mc_addr_out, 32'h0000_0200);
      fill(32'hAAAA_0200, 3);
      @(negedge clk_in);
      check("t3_resp_word", instr_out, 32'hAAAA_0200);
      step();
      set_req(1'b1, 32'h0000_0100);
      @(negedge clk_in);
      check("t3_evicted_miss", {31'd0, instr_valid_out}, 32'd0);
      step();
      @(negedge clk_in);
      check("t3_refetch_addr", mc_addr_out, 32'h0000_0100);
      fill(32'h0000_0013, 1);
      set_req(1'b0, 32'd0);
      step();

      // Flush during MISS: line filled, no reply, later request hits
      set_req(1'b1, 32'h0000_0104);
      step();
      set_req(1'b0, 32'd0);
      flush_in = 1'b1;
      step();
      flush_in = 1'b0;
      fill(32'h0BAD_F00D, 1);
      @(negedge clk_in);
      check("t4_dropped", {31'd0, instr_valid_out}, 32'd0);
      step();
      set_req(1'b1, 32'h0000_0104);
      @(negedge clk_in);
      check("t4_hit_valid", {31'd0, instr_valid_out}, 32'd1);
      check("t4_hit_word", instr_out, 32'h0BAD_F00D);
      step();
      set_req(1'b0, 32'd0);

      // mc_done_in together with flush_in: fill but no reply
      set_req(1'b1, 32'h0000_0108);
      step();
      set_req(1'b0, 32'd0);
      step();
      mc_done_in = 1'b1;
      mc_data_in = 32'hCAFE_0108;
      flush_in   = 1'b1;
      step();
      mc_done_in = 1'b0;
      mc_data_in = 32'd0;
      flush_in   = 1'b0;
      @(negedge clk_in);
      check("t4b_no_reply", {31'd0, instr_valid_out}, 32'd0);
      step();
      set_req(1'b1, 32'h0000_0108);
      @(negedge clk_in);
      check("t4b_hit_word", instr_out, 32'hCAFE_0108);
      step();
      set_req(1'b0, 32'd0);

      // Flush in IDLE with a miss: no request
      set_req(1'b1, 32'h0000_0500);
      flush_in = 1'b1;
      step();
      set_req(1'b0, 32'd0);
      flush_in = 1'b0;
      @(negedge clk_in);
      check("t4c_no_req", {31'd0, mc_req_out}, 32'd0);
      step();

      // rdy_in low for 5 cycles mid-MISS
      set_req(1'b1, 32'h0000_0300);
      step();
      @(negedge clk_in);
      check("t5_miss_cnt", miss_cnt_out, 32'd6);
      step();
      rdy_in = 1'b0;
      set_req(1'b1, 32'h0000_0104);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         check("t5_hold_req", {31'd0, mc_req_out}, 32'd1);
         check("t5_hold_addr", mc_addr_out, 32'h0000_0300);
         check("t5_hold_miss", miss_cnt_out, 32'd6);
         step();
      end
      rdy_in = 1'b1;
      set_req(1'b1, 32'h0000_0300);
      fill(32'h3333_0300, 2);
      @(negedge clk_in);
      check("t5_resp_word", instr_out, 32'h3333_0300);
      step();
      set_req(1'b0, 32'd0);
      step();

      // Hit counter wrap
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      m_hit = 32'hFFFF_FFFF;
      #1;
      release dut.hit_cnt_q;
      @(negedge clk_in);
      check("t6_preload", hit_cnt_out, 32'hFFFF_FFFF);
      step();
      set_req(1'b1, 32'h0000_0300);
      step();
      set_req(1'b0, 32'd0);
      @(negedge clk_in);
      check("t6_wrap", hit_cnt_out, 32'd0);
      step();

      // Reset asserted mid-MISS
      set_req(1'b1, 32'h0000_0400);
      step();
      @(negedge clk_in);
      check("t7_in_miss", {31'd0, mc_req_out}, 32'd1);
      step();
      rst_in = 1'b0;
      set_req(1'b0, 32'd0);
      @(negedge clk_in);
      check("t7_rst_req", {31'd0, mc_req_out}, 32'd0);
      check("t7_rst_miss", miss_cnt_out, 32'd0);
      step();
      rst_in     = 1'b1;
      mc_done_in = 1'b1;
      mc_data_in = 32'hDEAD_0400;
      step();
      mc_done_in = 1'b0;
      mc_data_in = 32'd0;
      @(negedge clk_in);
      check("t7_late_done_ignored", {31'd0, instr_valid_out}, 32'd0);
      step();
      set_req(1'b1, 32'h0000_0100);
      @(negedge clk_in);
      check("t7_lines_invalid", {31'd0, instr_valid_out}, 32'd0);
      step();
      @(negedge clk_in);
      check("t7_refetch_addr", mc_addr_out, 32'h0000_0100);
      fill(32'h0000_0013, 1);
      step();
      set_req(1'b0, 32'd0);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
